// File: rtl/riscuin_fetch_unit.sv
// riscuin_fetch_unit: instruction-fetch front end for RISCuinho.
// Issues word-addressed req/gnt requests, buffers in-order responses in a
// small FIFO and presents them to the decoder through a valid/ready handshake.
// Redirects flush the buffer and drop responses that are still in flight.
module riscuin_fetch_unit #(
  parameter int unsigned                   INSTR_ADDR_WIDTH = 10,
  parameter logic [INSTR_ADDR_WIDTH-1:0]   RESET_PC         = '0,
  parameter int unsigned                   FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic                        imem_req,
  output logic [INSTR_ADDR_WIDTH-1:0] imem_addr,
  input  logic                        imem_gnt,
  input  logic                        imem_rvalid,
  input  logic [31:0]                 imem_rdata,
  input  logic                        redirect,
  input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [31:0]                 instr,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_pc_plus,
  output logic                        pc_end
);

  localparam int unsigned IAW = INSTR_ADDR_WIDTH;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t         state, state_next;
  logic [IAW-1:0] fetch_pc;
  logic [IAW-1:0] resp_pc;
  logic [CW-1:0]  count, outstanding, discard;
  logic [CW-1:0]  outstanding_next;
  logic [CW:0]    credit_used;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic           grant, resp, drop, push, pop, last_grant;

  logic [31:0]    fifo_instr [FIFO_DEPTH];
  logic [IAW-1:0] fifo_pc    [FIFO_DEPTH];

  assign imem_addr     = fetch_pc;
  assign instr_valid   = (count != '0);
  assign instr         = instr_valid ? fifo_instr[rd_ptr] : NOP;
  assign instr_pc      = instr_valid ? fifo_pc[rd_ptr] : '0;
  assign instr_pc_plus = instr_pc + IAW'(1);

  // Request issue under credit, response classification and FIFO strobes.
  always_comb begin
    credit_used      = {1'b0, count} + {1'b0, outstanding};
    imem_req         = (state == FETCH) & en & ~redirect &
                       (credit_used < (CW+1)'(FIFO_DEPTH));
    grant            = imem_req & imem_gnt;
    resp             = imem_rvalid & (outstanding != '0);
    drop             = resp & (discard != '0);
    push             = resp & ~drop & ~redirect;
    pop              = instr_valid & instr_ready & ~redirect;
    last_grant       = grant & (fetch_pc == '1);
    outstanding_next = outstanding + CW'(grant) - CW'(resp);
  end

  // Next-state logic; a redirect restarts fetching from any state.
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = FETCH;
    end else begin
      case (state)
        IDLE:    if (en) state_next = FETCH;
        FETCH:   if (last_grant) state_next = HALT;
        default: state_next = state;
      endcase
    end
  end

  // Control state: PC, credit counters, FIFO pointers and end-of-memory flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pc_end      <= 1'b0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old
        // stream, so the discard budget is simply the post-edge outstanding
        // count; a response arriving this cycle is covered by the flush.
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        discard  <= outstanding_next;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        pc_end   <= 1'b0;
      end else begin
        if (grant)      fetch_pc <= fetch_pc + IAW'(1);
        if (last_grant) pc_end   <= 1'b1;
        if (drop)       discard  <= discard - CW'(1);
        if (push) begin
          resp_pc <= resp_pc + IAW'(1);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage; each entry carries the word address it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule
